mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//   Iterative MIPS multiply/divide unit with architectural HI/LO registers.
//   Sits directly downstream of RegFile: operands come from reg1o (rs) and reg2o (rt).
//   Executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle.
//   hi/lo feed the writeback mux for MFHI/MFLO. busy stalls the decode stage.
// PARAMETERS
//   WIDTH   32   operand width; hi/lo are WIDTH bits each
// PORTS
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-low reset (sampled on rising clk)
//   start   in   1      request; accepted only when busy=0
//   op      in   3      000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 reserved
//   opa     in   WIDTH  rs operand (from RegFile reg1o)
//   opb     in   WIDTH  rt operand (from RegFile reg2o)
//   busy    out  1      multi-cycle operation in progress
//   done    out  1      one-cycle pulse: hi/lo just updated by MULT*/DIV*
//   hi      out  WIDTH  HI register
//   lo      out  WIDTH  LO register
// BEHAVIOUR
//   Reset (reset=0 at an edge): state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Any
//     in-flight operation is discarded; reset wins over start on the same edge.
//   States: IDLE -> RUN -> FIX -> IDLE. busy=1 exactly in RUN and FIX.
//   IDLE, edge E0 with start=1:
//     MTHI: hi<=opa; MTLO: lo<=opa; stay IDLE, busy stays 0, no done pulse.
//     MULT*/DIV*: latch |opa|,|opb| (signed ops) or raw (unsigned ops), latch
//       result-sign flags, counter<=0, go RUN. Reserved op: ignored.
//   RUN: one shift-add (mult) or restoring shift-subtract (div) step per edge;
//     32 steps on edges E1..E32; after E32 -> FIX.
//   FIX, edge E33: apply sign fix-up, write hi/lo, -> IDLE; done=1 during the cycle
//     after E33 only. Total: busy high for 33 cycles; results visible after E33.
//   start while busy=1: ignored, no effect on operation, operands or hi/lo.
//   hi/lo hold previous values throughout RUN/FIX (MFHI during busy reads old value;
//     the stall is the consumer's job).
//   Arithmetic:
//     MULTU: {hi,lo} = opa*opb (64-bit unsigned).
//     MULT: 64-bit two's-complement product; negate magnitude product iff sign(a)^sign(b).
//     DIVU: lo = opa/opb, hi = opa%opb.
//     DIV: quotient truncates toward zero; quotient sign = sign(a)^sign(b), remainder
//       sign = sign(a). 0x80000000 / -1 -> lo=0x80000000, hi=0.
//     Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=opa (raw, no sign fix-up); still
//       takes the full 33 cycles.
//   Wrap-around: counter counts 0..31 only; no other overflow signalled.
// TESTING
//   1 reset=0 for 1 edge -> hi=0, lo=0, busy=0, done=0.
//   2 MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; done 1 cycle.
//   3 MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//   4 DIVU 7/0 -> lo=0xFFFFFFFF, hi=7; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   5 MTHI 0x12345678 then MTLO 0x9ABCDEF0 -> hi/lo update next edge, busy=0, no done;
//     start MULTU 2*3 during busy of a prior op -> ignored, prior result intact.
//   6 MULTU 5*5 then reset=0 at RUN cycle 10 -> busy=0, hi=lo=0, no done; next MULTU 5*5 -> lo=25.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// MULT*/DIV* take 33 busy cycles (32 shift steps + 1 sign fix-up); MTHI/MTLO are single-cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned DW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] acc_q, acc_d;     // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [W-1:0]  opb_q, opb_d;     // multiplicand / divisor magnitude
  logic          is_div_q, is_div_d;
  logic          pneg_q, pneg_d;   // negate product or quotient
  logic          rneg_q, rneg_d;   // negate remainder
  logic          dz_q, dz_d;       // divide by zero
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          sgn;
  logic [W-1:0]  a_mag, b_mag;
  logic [W:0]    sum;
  logic [W:0]    rem_sh;
  logic          ge;
  logic [W-1:0]  quo_fix, rem_fix;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      pneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      pneg_q   <= pneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state, iteration step and sign fix-up
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    pneg_d   = pneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    sgn     = (op == OP_MULT) || (op == OP_DIV);
    a_mag   = (sgn && opa[W-1]) ? -opa : opa;
    b_mag   = (sgn && opb[W-1]) ? -opb : opb;
    sum     = {1'b0, acc_q[DW-1:W]} + {1'b0, opb_q};
    rem_sh  = {acc_q[DW-1:W], acc_q[W-1]};
    ge      = rem_sh >= {1'b0, opb_q};
    quo_fix = pneg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix = rneg_q ? -acc_q[DW-1:W] : acc_q[DW-1:W];

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MTHI: hi_d = opa;
            OP_MTLO: lo_d = opa;
            OP_MULTU, OP_MULT, OP_DIVU, OP_DIV: begin
              acc_d    = {{W{1'b0}}, a_mag};
              opb_d    = b_mag;
              is_div_d = op[1];
              pneg_d   = sgn && (opa[W-1] ^ opb[W-1]);
              rneg_d   = sgn && opa[W-1];
              dz_d     = (opb == '0);
              cnt_d    = '0;
              state_d  = S_RUN;
              busy_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_d = {W'(ge ? rem_sh - {1'b0, opb_q} : rem_sh), acc_q[W-2:0], ge};
        end else if (acc_q[0]) begin
          acc_d = {sum, acc_q[W-1:1]};
        end else begin
          acc_d = {1'b0, acc_q[DW-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        // A zero divisor leaves remainder = |a|, so the remainder fix-up restores raw opa
        if (is_div_q) begin
          lo_d = dz_q ? '1 : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = pneg_q ? -acc_q : acc_q;
        end
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit with a 64-bit arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int passed = 0;
  int total  = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .opa  (opa),
    .opb  (opb),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  // Reference result {hi, lo} from plain arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (o)
      3'd0: r = {32'b0, a} * {32'b0, b};
      3'd1: r = 64'(sa * sb);
      3'd2: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      3'd3: begin
        if (b == 0) begin
          r = {a, 32'hFFFFFFFF};
        end else begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    opa   = a;
    opb   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Observe 40 cycles after acceptance: busy cycles, done pulses, hi/lo stability while busy
  task automatic wait_done(output int bc, output int dp, output bit held);
    logic [31:0] h0, l0;
    h0 = hi;
    l0 = lo;
    bc = 0;
    dp = 0;
    held = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        bc++;
        if (hi !== h0 || lo !== l0) held = 1'b0;
      end
      if (done === 1'b1) dp++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b1;
    op    = 3'd0;
    opa   = 32'd9;
    opb   = 32'd9;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    total++; if (hi !== 32'h0) $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); else passed++;
    total++; if (lo !== 32'h0) $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else passed++;
  endtask

  task automatic test_multu_max();
    int bc, dp;
    bit held;
    issue(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(bc, dp, held);
    total++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) $display("FAIL multu_max got=%h_%h exp=fffffffe_00000001", hi, lo); else passed++;
    total++; if (bc != 33) $display("FAIL multu_busy_cycles got=%0d exp=33", bc); else passed++;
    total++; if (dp != 1) $display("FAIL multu_done_pulses got=%0d exp=1", dp); else passed++;
    total++; if (!held) $display("FAIL multu_hold_while_busy got=changed exp=stable"); else passed++;
  endtask

  task automatic test_fixed_cases();
    logic [2:0]  ops [6];
    logic [31:0] as  [6];
    logic [31:0] bs  [6];
    logic [63:0] exp [6];
    int bc, dp;
    bit held;
    ops[0] = 3'd1; as[0] = 32'hFFFFFFFD; bs[0] = 32'd7;        exp[0] = 64'hFFFFFFFF_FFFFFFEB;
    ops[1] = 3'd3; as[1] = 32'hFFFFFFF9; bs[1] = 32'd2;        exp[1] = 64'hFFFFFFFF_FFFFFFFD;
    ops[2] = 3'd2; as[2] = 32'd7;        bs[2] = 32'd0;        exp[2] = 64'h00000007_FFFFFFFF;
    ops[3] = 3'd3; as[3] = 32'h80000000; bs[3] = 32'hFFFFFFFF; exp[3] = 64'h00000000_80000000;
    ops[4] = 3'd3; as[4] = 32'hFFFFFFF9; bs[4] = 32'd0;        exp[4] = 64'hFFFFFFF9_FFFFFFFF;
    ops[5] = 3'd3; as[5] = 32'd7;        bs[5] = 32'hFFFFFFFE; exp[5] = 64'h00000001_FFFFFFFD;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_done(bc, dp, held);
      total++;
      if ({hi, lo} !== exp[i])
        $display("FAIL fixed_case%0d op=%0d a=%h b=%h got=%h_%h exp=%h", i, ops[i], as[i], bs[i], hi, lo, exp[i]);
      else passed++;
      if (ops[i] == 3'd2) begin
        total++; if (bc != 33) $display("FAIL divzero_busy_cycles got=%0d exp=33", bc); else passed++;
      end
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    start = 1'b1; op = 3'd4; opa = 32'h12345678; opb = 32'h0;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (hi !== 32'h12345678) $display("FAIL mthi_hi got=%h exp=12345678", hi); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mthi_flags got=%b%b exp=00", busy, done); else passed++;
    @(negedge clk);
    start = 1'b1; op = 3'd5; opa = 32'h9ABCDEF0;
    @(posedge clk); #1;
    start = 1'b0;
    total++; if ({hi, lo} !== 64'h12345678_9ABCDEF0) $display("FAIL mtlo_hilo got=%h_%h exp=12345678_9abcdef0", hi, lo); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mtlo_flags got=%b%b exp=00", busy, done); else passed++;
    @(negedge clk);
    start = 1'b1; op = 3'd6; opa = 32'h1111; opb = 32'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++; if ({hi, lo} !== 64'h12345678_9ABCDEF0 || busy !== 1'b0) $display("FAIL reserved_op got=%h_%h busy=%b exp=12345678_9abcdef0 busy=0", hi, lo, busy); else passed++;
  endtask

  task automatic test_busy_ignore();
    int bc, dp;
    bit held;
    issue(3'd0, 32'd5, 32'd7);
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd0; opa = 32'd2; opb = 32'd3;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done(bc, dp, held);
    total++; if ({hi, lo} !== 64'd35) $display("FAIL busy_ignore_result got=%h_%h exp=0_23", hi, lo); else passed++;
    total++; if (dp != 1 || busy !== 1'b0) $display("FAIL busy_ignore_done got=%0d busy=%b exp=1 busy=0", dp, busy); else passed++;
  endtask

  task automatic test_reset_midrun();
    int bc, dp;
    bit held;
    issue(3'd0, 32'd5, 32'd5);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    total++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) $display("FAIL midrun_reset got=busy%b %h_%h exp=busy0 0_0", busy, hi, lo); else passed++;
    dp = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dp++;
    end
    total++; if (dp != 0) $display("FAIL midrun_no_done got=%0d exp=0", dp); else passed++;
    issue(3'd0, 32'd5, 32'd5);
    wait_done(bc, dp, held);
    total++; if ({hi, lo} !== 64'd25) $display("FAIL midrun_rerun got=%h_%h exp=0_19", hi, lo); else passed++;
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    logic [63:0] exp;
    int bc, dp;
    bit held;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: a = 32'h80000000;
        2: b = 32'($urandom_range(1, 15));
        3: b = 32'hFFFFFFFF;
        default: ;
      endcase
      exp = ref_model(o, a, b);
      issue(o, a, b);
      wait_done(bc, dp, held);
      total++;
      if ({hi, lo} !== exp || bc != 33 || dp != 1)
        $display("FAIL random%0d op=%0d a=%h b=%h got=%h_%h bc=%0d dp=%0d exp=%h bc=33 dp=1", i, o, a, b, hi, lo, bc, dp, exp);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_fixed_cases();
    test_mthi_mtlo();
    test_busy_ignore();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
